// File: rtl/scoreboard_warp.sv
// Per-warp scoreboard: tracks in-flight instructions that still owe a
// register write or a memory replay, reports hazard/occupancy status to the
// instruction buffer and hands out the entry ID used by the next allocation.
module scoreboard_warp #(
  parameter int NUM_ENTRIES    = 4,
  parameter int LOGNUM_ENTRIES = $clog2(NUM_ENTRIES),
  parameter int REG_W          = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_W-1:0]          src1_IB_Scb,
  input  logic [REG_W-1:0]          src2_IB_Scb,
  input  logic [REG_W-1:0]          dst_IB_Scb,
  input  logic                      src1_valid_IB_Scb,
  input  logic                      src2_valid_IB_Scb,
  input  logic                      dst_valid_IB_Scb,
  input  logic                      replayable_IB_Scb,
  input  logic                      RP_grt_IB_Scb,
  input  logic                      replay_complete_IB_Scb,
  input  logic [LOGNUM_ENTRIES-1:0] replay_complete_ScbID_IB_Scb,
  input  logic                      replay_SW_LWbar_IB_Scb,
  input  logic                      clear_valid_WB_Scb,
  input  logic [LOGNUM_ENTRIES-1:0] clear_ScbID_WB_Scb,
  output logic                      full_Scb_IB,
  output logic                      empty_Scb_IB,
  output logic                      dependent_Scb_IB,
  output logic [LOGNUM_ENTRIES-1:0] ScbID_Scb_IB
);

  logic [NUM_ENTRIES-1:0] entry_valid;
  logic [NUM_ENTRIES-1:0] entry_dst_valid;
  logic [NUM_ENTRIES-1:0] entry_incomplete;
  logic [REG_W-1:0]       entry_dst [NUM_ENTRIES];

  logic alloc;

  // Occupancy flags come purely from registered valid bits, so same-cycle
  // allocations or frees only show up after the edge.
  assign full_Scb_IB  = &entry_valid;
  assign empty_Scb_IB = ~|entry_valid;

  // Only instructions that owe a register write or a replay need an entry.
  assign alloc = RP_grt_IB_Scb && !full_Scb_IB &&
                 (dst_valid_IB_Scb || replayable_IB_Scb);

  // Pick the lowest-numbered free entry; scanning downward lets the lowest win.
  always_comb begin
    ScbID_Scb_IB = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid[i]) ScbID_Scb_IB = i[LOGNUM_ENTRIES-1:0];
    end
  end

  // Hazard check of the head instruction: RAW on either source, WAW on the
  // destination, and any outstanding replay blocks another memory op.
  always_comb begin
    dependent_Scb_IB = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entry_valid[i]) begin
        if (entry_dst_valid[i]) begin
          if (src1_valid_IB_Scb && (src1_IB_Scb == entry_dst[i])) dependent_Scb_IB = 1'b1;
          if (src2_valid_IB_Scb && (src2_IB_Scb == entry_dst[i])) dependent_Scb_IB = 1'b1;
          if (dst_valid_IB_Scb  && (dst_IB_Scb  == entry_dst[i])) dependent_Scb_IB = 1'b1;
        end
        if (replayable_IB_Scb && entry_incomplete[i]) dependent_Scb_IB = 1'b1;
      end
    end
  end

  // Entry state update: frees from writeback and replay completion, then
  // allocation into an entry that was free before the edge (never collides).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_valid      <= '0;
      entry_dst_valid  <= '0;
      entry_incomplete <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) entry_dst[i] <= '0;
    end else begin
      if (clear_valid_WB_Scb && entry_valid[clear_ScbID_WB_Scb]) begin
        entry_valid[clear_ScbID_WB_Scb]      <= 1'b0;
        entry_incomplete[clear_ScbID_WB_Scb] <= 1'b0;
      end
      if (replay_complete_IB_Scb && entry_valid[replay_complete_ScbID_IB_Scb] &&
          entry_incomplete[replay_complete_ScbID_IB_Scb]) begin
        entry_incomplete[replay_complete_ScbID_IB_Scb] <= 1'b0;
        if (replay_SW_LWbar_IB_Scb) entry_valid[replay_complete_ScbID_IB_Scb] <= 1'b0;
      end
      if (alloc) begin
        entry_valid[ScbID_Scb_IB]      <= 1'b1;
        entry_dst[ScbID_Scb_IB]        <= dst_IB_Scb;
        entry_dst_valid[ScbID_Scb_IB]  <= dst_valid_IB_Scb;
        entry_incomplete[ScbID_Scb_IB] <= replayable_IB_Scb;
      end
    end
  end

endmodule
